// File: rtl/fsbm_pkg.sv
// Shared widths, writer state encoding and result-word packing for the FSBM result path.
package fsbm_pkg;

  localparam int ADDR_W = 22;
  localparam int MV_W   = 8;
  localparam int SAD_W  = 18;
  localparam int DATA_W = 2 * MV_W + SAD_W;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} wr_state_e;

  typedef struct packed {
    logic [MV_W-1:0]  mv_x;
    logic [MV_W-1:0]  mv_y;
    logic [SAD_W-1:0] sad;
  } res_word_t;

  // Raw bit concatenation: signed vector components are stored as-is, no extension.
  function automatic logic [DATA_W-1:0] pack_result(
    input logic [MV_W-1:0]  mv_x,
    input logic [MV_W-1:0]  mv_y,
    input logic [SAD_W-1:0] sad
  );
    res_word_t w;
    w.mv_x = mv_x;
    w.mv_y = mv_y;
    w.sad  = sad;
    return w;
  endfunction

endpackage

// File: rtl/fsbm_sync_fifo.sv
// Synchronous FIFO, count-based full/empty flags, head read straight from storage flops.
// Push and pop may coincide; a push while full or a pop while empty is dropped.
module fsbm_sync_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head_dat
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_push;
  logic             w_pop;

  assign full     = (r_count == CNT_FULL);
  assign empty    = (r_count == '0);
  assign w_push   = push && !full;
  assign w_pop    = pop && !empty;
  assign head_dat = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= push_dat;
        r_wr_ptr        <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_ONE;
      if (w_push && !w_pop)      r_count <= r_count + CNT_ONE;
      else if (w_pop && !w_push) r_count <= r_count - CNT_ONE;
    end
  end

endmodule

// File: rtl/fsbm_result_writer.sv
// Packs per-block {mv_x, mv_y, sad} results and writes them to consecutive result-memory words per frame.
// Writes start one cycle after acceptance; res_ready drops when the buffer fills, writes hold while mem_ready is low.
module fsbm_result_writer
  import fsbm_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] num_words,
  input  logic              res_valid,
  output logic              res_ready,
  input  logic [MV_W-1:0]   res_mv_x,
  input  logic [MV_W-1:0]   res_mv_y,
  input  logic [SAD_W-1:0]  res_sad,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  input  logic              mem_ready,
  output logic              busy,
  output logic              done,
  output logic              wrap_err
);

  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  wr_state_e         r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_num;
  logic [ADDR_W-1:0] r_acc_cnt;
  logic [ADDR_W-1:0] r_wr_cnt;
  logic              r_wrap_err;

  logic              w_active;
  logic              w_full;
  logic              w_empty;
  logic              w_accept;
  logic              w_write;
  logic [ADDR_W-1:0] w_acc_next;
  logic [ADDR_W-1:0] w_wr_next;
  logic [DATA_W-1:0] w_push_dat;
  logic [DATA_W-1:0] w_head_dat;

  assign w_active   = (r_state == RUN) || (r_state == DRAIN);
  assign res_ready  = (r_state == RUN) && !w_full;
  assign w_accept   = res_valid && res_ready;
  assign mem_wr_en  = w_active && !w_empty;
  assign w_write    = mem_wr_en && mem_ready;
  assign w_acc_next = r_acc_cnt + ADDR_ONE;
  assign w_wr_next  = r_wr_cnt + ADDR_ONE;
  assign w_push_dat = pack_result(res_mv_x, res_mv_y, res_sad);

  assign mem_addr = r_addr;
  assign mem_data = w_head_dat;
  assign busy     = w_active;
  assign done     = (r_state == DONE);
  assign wrap_err = r_wrap_err;

  fsbm_sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (w_accept),
    .push_dat (w_push_dat),
    .pop      (w_write),
    .full     (w_full),
    .empty    (w_empty),
    .head_dat (w_head_dat)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_addr     <= '0;
      r_num      <= '0;
      r_acc_cnt  <= '0;
      r_wr_cnt   <= '0;
      r_wrap_err <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_addr     <= base_addr;
          r_num      <= num_words;
          r_acc_cnt  <= '0;
          r_wr_cnt   <= '0;
          r_wrap_err <= 1'b0;
          r_state    <= (num_words == '0) ? DONE : RUN;
        end
        RUN: if (w_accept) begin
          r_acc_cnt <= w_acc_next;
          if (w_acc_next == r_num) r_state <= DRAIN;
        end
        DRAIN: if (w_write && (w_wr_next == r_num)) r_state <= DONE;
        DONE: r_state <= IDLE;
      endcase
      // Writes drain in both RUN and DRAIN, never in IDLE, so this cannot race the start load.
      if (w_write) begin
        r_addr   <= r_addr + ADDR_ONE;
        r_wr_cnt <= w_wr_next;
        if (r_addr == ADDR_MAX) r_wrap_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fsbm_result_writer.sv
// Bench for fsbm_result_writer: table frame, hand-built corner sequences and random frames
// checked against a frame-level model (sequential addresses modulo 2^22, words in acceptance order).
module tb_fsbm_result_writer;
  import fsbm_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n, start, res_valid, res_ready, mem_wr_en, mem_ready;
  logic              busy, done, wrap_err;
  logic [ADDR_W-1:0] base_addr, num_words, mem_addr;
  logic [MV_W-1:0]   res_mv_x, res_mv_y;
  logic [SAD_W-1:0]  res_sad;
  logic [DATA_W-1:0] mem_data;

  fsbm_result_writer #(.FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .num_words(num_words),
    .res_valid(res_valid), .res_ready(res_ready), .res_mv_x(res_mv_x), .res_mv_y(res_mv_y),
    .res_sad(res_sad), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_ready(mem_ready), .busy(busy), .done(done), .wrap_err(wrap_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: logs every completed write and every accepted result; checks the hold rule.
  logic [ADDR_W-1:0] wa_q[$];
  logic [DATA_W-1:0] wd_q[$];
  logic [DATA_W-1:0] ad_q[$];
  int                wc_q[$];
  int                ac_q[$];
  logic              we_q[$];
  int                done_cnt = 0;
  int                done_cyc = 0;
  int                wr_en_cnt = 0;
  logic              hold_pend = 1'b0;
  logic [ADDR_W-1:0] hold_addr;
  logic [DATA_W-1:0] hold_data;

  always @(negedge clk) begin
    if (rst_n !== 1'b1) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) begin
        chk("hold_wr_en", mem_wr_en, 1);
        chk("hold_addr", mem_addr, hold_addr);
        chk("hold_data", mem_data, hold_data);
      end
      hold_pend = mem_wr_en && !mem_ready;
      hold_addr = mem_addr;
      hold_data = mem_data;
      chk("ready_outside_busy", res_ready && !busy, 0);
      if (mem_wr_en) wr_en_cnt++;
      if (mem_wr_en && mem_ready) begin
        wa_q.push_back(mem_addr);
        wd_q.push_back(mem_data);
        wc_q.push_back(cyc);
        we_q.push_back(wrap_err);
      end
      if (res_valid && res_ready) begin
        ad_q.push_back(pack_result(res_mv_x, res_mv_y, res_sad));
        ac_q.push_back(cyc);
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  typedef struct {
    logic [MV_W-1:0]   mx;
    logic [MV_W-1:0]   my;
    logic [SAD_W-1:0]  sad;
    logic [ADDR_W-1:0] ea;
    logic [DATA_W-1:0] ed;
  } vec_t;
  vec_t tbl[6];

  int s_cyc, w0, a0, e_snap, a_snap, early;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string pfx);
    chk({pfx, "_res_ready"}, res_ready, 0);
    chk({pfx, "_mem_wr_en"}, mem_wr_en, 0);
    chk({pfx, "_mem_addr"}, mem_addr, 0);
    chk({pfx, "_mem_data"}, mem_data, 0);
    chk({pfx, "_busy"}, busy, 0);
    chk({pfx, "_done"}, done, 0);
    chk({pfx, "_wrap_err"}, wrap_err, 0);
  endtask

  // vmode 0: valid every cycle, 1: random. rmode 0: ready high, 1: random, 2: low for 10 cycles.
  task automatic do_frame(input logic [ADDR_W-1:0] base, input int n, input int vmode,
                          input int rmode, input bit use_tbl, input bit restart);
    int k, sent, d0, e0, budget, nw;
    bit pend, wr_seen;
    logic [ADDR_W-1:0] ea;
    w0 = wa_q.size(); a0 = ad_q.size(); d0 = done_cnt; e0 = wr_en_cnt;
    budget = 30 * n + 50;
    start = 1'b1; base_addr = base; num_words = ADDR_W'(n);
    mem_ready = (rmode == 0); res_valid = 1'b0;
    s_cyc = cyc;
    tick();
    start = 1'b0;
    k = 0; sent = 0; pend = 0;
    while (done_cnt == d0 && k < budget) begin
      if (restart && k == 2) begin
        start = 1'b1; base_addr = base ^ 22'h155; num_words = ADDR_W'(n + 3);
      end else begin
        start = 1'b0;
      end
      case (rmode)
        0:       mem_ready = 1'b1;
        1:       mem_ready = 1'($urandom_range(0, 1));
        default: mem_ready = (k >= 10);
      endcase
      if (!pend) begin
        res_valid = 1'b0;
        if (sent < n && (vmode == 0 || $urandom_range(0, 3) != 0)) begin
          res_valid = 1'b1; pend = 1;
          if (use_tbl) begin
            res_mv_x = tbl[sent].mx; res_mv_y = tbl[sent].my; res_sad = tbl[sent].sad;
          end else begin
            res_mv_x = MV_W'($urandom); res_mv_y = MV_W'($urandom); res_sad = SAD_W'($urandom);
          end
        end
      end
      @(negedge clk);
      if (res_valid && res_ready) begin
        sent++; pend = 0;
      end
      tick();
      k++;
    end
    start = 1'b0; res_valid = 1'b0; mem_ready = 1'b1;
    chk("frame_done_within_budget", k < budget, 1);
    @(negedge clk); #1;
    chk("done_pulse_one_cycle", done, 0);
    chk("done_count", done_cnt - d0, 1);
    nw = wa_q.size() - w0;
    chk("n_writes", nw, n);
    chk("n_accepts", ad_q.size() - a0, n);
    if (n == 0) begin
      chk("zero_done_cycle", done_cyc, s_cyc + 1);
      chk("zero_no_wr_en", wr_en_cnt - e0, 0);
    end else if (nw > 0) begin
      chk("done_after_last_write", done_cyc, wc_q[$] + 1);
    end
    wr_seen = 0;
    for (int i = 0; i < nw && i < n; i++) begin
      ea = base + ADDR_W'(i);
      if (use_tbl) begin
        chk("tbl_addr", wa_q[w0 + i], tbl[i].ea);
        chk("tbl_data", wd_q[w0 + i], tbl[i].ed);
      end else begin
        chk("wr_addr", wa_q[w0 + i], ea);
        if (a0 + i < ad_q.size()) chk("wr_data", wd_q[w0 + i], ad_q[a0 + i]);
      end
      if (a0 + i < ad_q.size()) chk("wr_after_accept", wc_q[w0 + i] > ac_q[a0 + i], 1);
      chk("wrap_at_write", we_q[w0 + i], wr_seen);
      if (ea == '1) wr_seen = 1;
    end
    chk("wrap_after_frame", wrap_err, wr_seen);
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not reach the end of the test");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; base_addr = '0; num_words = '0; res_valid = 1'b0;
    res_mv_x = '0; res_mv_y = '0; res_sad = '0; mem_ready = 1'b0;

    tbl[0] = '{8'h01, 8'hFF, 18'd100,     22'h100, 34'h0_07FC_0064};
    tbl[1] = '{8'h02, 8'hFE, 18'd200,     22'h101, 34'h0_0BF8_00C8};
    tbl[2] = '{8'h03, 8'hFD, 18'd300,     22'h102, 34'h0_0FF4_012C};
    tbl[3] = '{8'h04, 8'hFC, 18'd400,     22'h103, 34'h0_13F0_0190};
    tbl[4] = '{8'h80, 8'h7F, 18'h3FFFF,   22'h104, 34'h2_01FF_FFFF};
    tbl[5] = '{8'hFF, 8'hFF, 18'h3FFFF,   22'h105, 34'h3_FFFF_FFFF};

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_zero("reset");
    tick();
    rst_n = 1'b1;
    tick();

    do_frame(22'h100, 6, 0, 0, 1, 0);

    // Memory stalled for 10 cycles: only the buffer depth may be accepted meanwhile.
    do_frame(22'h400, 6, 0, 2, 0, 0);
    early = 0;
    for (int i = a0; i < ad_q.size(); i++) if (ac_q[i] <= s_cyc + 10) early++;
    chk("bp_accepts_while_stalled", early, 4);

    do_frame(22'h3FFFFE, 3, 0, 0, 0, 0);
    if (wa_q.size() == w0 + 3) chk("wrap_third_addr", wa_q[w0 + 2], 22'h000000);
    tick();
    chk("wrap_sticky_idle", wrap_err, 1);

    do_frame(22'h055, 0, 0, 0, 0, 0);
    do_frame(22'h800, 5, 1, 1, 0, 1);

    // Reset with three words stuck behind a stalled memory.
    start = 1'b1; base_addr = 22'h200; num_words = 22'd8; mem_ready = 1'b0;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      res_valid = 1'b1; res_mv_x = MV_W'(i + 5); res_mv_y = MV_W'(i); res_sad = SAD_W'(i * 7);
      tick();
    end
    res_valid = 1'b0;
    @(negedge clk); #1;
    chk("pre_rst_wr_en", mem_wr_en, 1);
    chk("pre_rst_busy", busy, 1);
    tick();
    rst_n = 1'b0; mem_ready = 1'b1;
    tick();
    rst_n = 1'b1;
    @(negedge clk); #1;
    chk_zero("midrst");
    e_snap = wr_en_cnt; a_snap = ad_q.size();
    tick();
    res_valid = 1'b1;
    repeat (6) tick();
    res_valid = 1'b0;
    chk("no_wr_after_rst", wr_en_cnt - e_snap, 0);
    chk("no_accept_after_rst", ad_q.size() - a_snap, 0);
    do_frame(22'h010, 3, 0, 0, 0, 0);
    if (wa_q.size() > w0) chk("post_rst_first_addr", wa_q[w0], 22'h010);

    do_frame(ADDR_W'($urandom), 64, 0, 0, 0, 0);
    if (ac_q.size() > a0 && wc_q.size() > w0) begin
      chk("stream_first_accept", ac_q[a0], s_cyc + 1);
      chk("stream_latency", wc_q[w0], ac_q[a0] + 1);
    end
    for (int i = 1; i < 64 && w0 + i < wc_q.size(); i++)
      chk("stream_gap", wc_q[w0 + i], wc_q[w0] + i);

    for (int f = 0; f < 8; f++) begin
      logic [ADDR_W-1:0] b;
      int n;
      b = (f % 2 == 1) ? (22'h3FFFFF - ADDR_W'($urandom_range(0, 20))) : ADDR_W'($urandom);
      n = $urandom_range(1, 40);
      do_frame(b, n, 1, 1, 0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fsbm_result_writer.md
# fsbm_result_writer

Result-capture writer for the full-search block-matching datapath. It accepts one best-match result per block from the matching engine: motion vector plus SAD. It packs each result into a 34-bit word and writes the words sequentially into the 22-bit-addressed result memory, the same 34-bit × 2^22 word space the stimulus memory model reads from. A small FIFO absorbs memory back-pressure, and a frame-level start/done handshake delimits each capture.

## Interface
- ADDR_W, 22, memory address width
- DATA_W, 34, memory word width (= MV_W*2 + SAD_W)
- MV_W, 8, signed motion-vector component width
- SAD_W, 18, SAD width
- FIFO_DEPTH, 4, result buffer depth (power of two, ≥2)

- clk  in  1  rising-edge clock; single clock domain
- rst_n  in  1  synchronous, active-low reset
- start  in  1  one-cycle pulse; latches base_addr and num_words
- base_addr  in  ADDR_W  first write address
- num_words  in  ADDR_W  results expected this frame
- res_valid  in  1  result valid
- res_ready  out  1  writer can accept result
- res_mv_x  in  MV_W  signed horizontal vector
- res_mv_y  in  MV_W  signed vertical vector
- res_sad  in  SAD_W  unsigned SAD
- mem_wr_en  out  1  write request
- mem_addr  out  ADDR_W  write address
- mem_data  out  DATA_W  write data
- mem_ready  in  1  memory accepts write this cycle
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse after last write
- wrap_err  out  1  sticky; address wrapped past 2^ADDR_W-1

## Operation
- Packing: mem_data = {res_mv_x, res_mv_y, res_sad}, with mv_x in bits [33:26], mv_y in [25:18], and sad in [17:0]. There is no sign extension or saturation; bits pass through.
- FSM states:
  - IDLE → RUN on start when num_words≠0.
  - IDLE → DONE on start when num_words=0.
  - RUN → DRAIN when the accepted count reaches num_words.
  - DRAIN → DONE when the written count reaches num_words.
  - DONE → IDLE unconditionally.
- start is ignored outside IDLE.
- res_ready = (state==RUN) && !fifo_full. The writer never accepts results in IDLE, DRAIN or DONE.
- Acceptance is res_valid && res_ready. An accepted result is pushed into the FIFO and increments acc_cnt.
- mem_wr_en = !fifo_empty in RUN or DRAIN. mem_addr/mem_data come from the FIFO head and the address register.
- A write completes on mem_wr_en && mem_ready. On completion the FIFO pops, wr_cnt increments, and the address increments modulo 2^ADDR_W.
- Wrap: when a write completes at address 2^ADDR_W-1, the address becomes 0 and wrap_err sets. wrap_err clears only on reset or on the next accepted start.
- busy = state ∈ {RUN, DRAIN}.
- done is high only in DONE.

## Timing
- Reset values: res_ready=0, mem_wr_en=0, mem_addr=0, mem_data=0, busy=0, done=0, wrap_err=0. The FIFO is empty and the counters are 0.
- Reset mid-frame: on the next edge, pending FIFO contents are discarded and no further writes are issued.
- start is sampled at edge N; busy and res_ready are high from edge N+1.
- Latency: a result accepted at edge N drives mem_wr_en from edge N+1 at the earliest (registered FIFO, no bypass).
- Throughput is one write per cycle when mem_ready stays high.
- Hold rule: while mem_wr_en && !mem_ready, mem_addr and mem_data stay stable and mem_wr_en stays high.
- Simultaneous push and pop: both are allowed in the same cycle and the FIFO occupancy is unchanged. res_ready is evaluated on the registered full flag, with no same-cycle pop look-ahead.
- done pulse timing:
  - It rises the cycle after the final write completes and lasts exactly one cycle.
  - For num_words=0 it rises the cycle after start.

## Structure
- Shared package fsbm_pkg holds:
  - ADDR_W, DATA_W, MV_W and SAD_W constants;
  - the writer state enum (IDLE, RUN, DRAIN, DONE);
  - a pack_result(mv_x, mv_y, sad) function, reused by the bench's checker.
- One sub-module: fsbm_sync_fifo. It is a parameterised synchronous FIFO (width DATA_W, depth FIFO_DEPTH) with push, pop, full, empty and a registered head output, reset by rst_n.
- The FSM, counters and address register live in the top.

## Test plan
- Basic frame: base_addr=0x000100, num_words=4, mem_ready=1, results (1,-1,100),(2,-2,200),(3,-3,300),(4,-4,400) → writes at 0x100–0x103. The first word is 0x07FC0064, since -1 packs to 8'hFF. done pulses exactly once, after the 4th write.
- Back-pressure: mem_ready is low for 10 cycles while 6 results are offered → res_ready drops after 4 accepted. mem_addr/mem_data are held constant. All 6 words are written in order once mem_ready rises.
- Wrap: base_addr=0x3FFFFE, num_words=3 → writes land at 0x3FFFFE, 0x3FFFFF and 0x000000. wrap_err sets after the 2nd write and stays set through done.
- Zero-length and ignored start: num_words=0 → done is high one cycle after start and no mem_wr_en occurs. A second start issued while busy does not change mem_addr.
- Reset mid-frame: rst_n is low for 1 cycle with 3 words in the FIFO → all outputs are 0 the next cycle. No writes occur until a new start. The new frame from base_addr=0x10 writes 0x10 first.
- Full-rate stream: num_words=64 with continuous res_valid and mem_ready=1 → 64 consecutive write cycles after 1 cycle of latency, and no gaps.
